// File: rtl/mul_arbiter_pkg.sv
// Shared Q4.28 fixed-point constants and the default multiplier latency.
package mul_arbiter_pkg;
  localparam int unsigned        Q_WIDTH     = 32;
  localparam int unsigned        Q_FRAC      = 28;
  localparam logic [Q_WIDTH-1:0] Q_ONE       = 32'h1000_0000;
  localparam int unsigned        MUL_LATENCY = 3;

  typedef logic signed [Q_WIDTH-1:0] q4_28_t;
endpackage

// File: rtl/mul_arbiter_fixed_mul.sv
// Pipelined signed fixed-point multiplier: LAT cycles valid_in -> valid_out,
// truncated product bits [FRAC+WIDTH-1:FRAC].
module fixed_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 28,
  parameter int unsigned LAT   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    valid_out,
  output logic        [WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] prod_full;
  logic                      unused_prod;
  logic [LAT-1:0]            v_pipe;
  logic [WIDTH-1:0]          p_pipe [LAT];

  assign prod_full   = a * b;
  assign unused_prod = ^prod_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= valid_in;
      for (int unsigned i = 1; i < LAT; i++) v_pipe[i] <= v_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    p_pipe[0] <= prod_full[FRAC+WIDTH-1:FRAC];
    for (int unsigned i = 1; i < LAT; i++) p_pipe[i] <= p_pipe[i-1];
  end

  assign valid_out = v_pipe[LAT-1];
  assign p         = p_pipe[LAT-1];
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined Q4.28 multiplier among N_REQ requesters.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = Q_WIDTH,
  parameter int unsigned FRAC    = Q_FRAC,
  parameter int unsigned MUL_LAT = MUL_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*WIDTH-1:0]       req_a,
  input  logic [N_REQ*WIDTH-1:0]       req_b,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic [$clog2(MUL_LAT+2)-1:0] in_flight
);
  localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             found;
  logic             xfer;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_valid;
  logic [WIDTH-1:0] mul_p;
  logic [MUL_LAT-1:0] tag_v;
  logic [IDX_W-1:0]   tag_idx [MUL_LAT];

  // Cyclic search starting at rr_ptr; first valid requester wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign xfer = found & en & ~rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  assign mul_a = req_a[grant_idx*WIDTH +: WIDTH];
  assign mul_b = req_b[grant_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  fixed_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .LAT   (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst_n     (~rst),
    .valid_in  (xfer),
    .a         (mul_a),
    .b         (mul_b),
    .valid_out (mul_valid),
    .p         (mul_p)
  );

  // Tag pipeline mirrors the multiplier stages so the index exits with its product.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= xfer;
      for (int unsigned i = 1; i < MUL_LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_idx[0] <= grant_idx;
    for (int unsigned i = 1; i < MUL_LAT; i++) tag_idx[i] <= tag_idx[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_v[MUL_LAT-1] && mul_valid) begin
        rsp_valid[tag_idx[MUL_LAT-1]] <= 1'b1;
        rsp_data                      <= mul_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({xfer, |rsp_valid})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter (N_REQ=4, Q4.28, MUL_LAT=3).
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [2:0]     in_flight;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mul_arbiter #(
    .N_REQ   (4),
    .WIDTH   (32),
    .FRAC    (28),
    .MUL_LAT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .in_flight (in_flight)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  int exp_inf;
  int done_cnt;
  logic [N-1:0] exp_ready;
  logic [N-1:0] exp_rsp;

  initial begin
    rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;

    // Reset behaviour
    next_cycle(); req_valid = '1; settle();
    check("rst_ready_forced_zero", req_ready, 0);
    next_cycle(); req_valid = '0; settle();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_in_flight", in_flight, 0);
    rst = 1'b0; settle();
    check("idle_ready_zero", req_ready, 0);

    // Single request from requester 2: 2.0 * 1.5 = 3.0
    next_cycle();
    set_op(2, 32'h2000_0000, 32'h1800_0000);
    req_valid = 4'b0100; settle();
    check("single_ready", req_ready, 4'b0100);
    next_cycle(); req_valid = '0; settle();
    check("single_inflight_t1", in_flight, 1);
    check("single_no_rsp_t1", rsp_valid, 0);
    next_cycle(); settle();
    check("single_no_rsp_t2", rsp_valid, 0);
    next_cycle(); settle();
    check("single_no_rsp_t3", rsp_valid, 0);
    next_cycle(); settle();
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_rsp_data", rsp_data, 32'h3000_0000);
    check("single_inflight_t4", in_flight, 1);
    next_cycle(); settle();
    check("single_rsp_clear", rsp_valid, 0);
    check("single_data_held", rsp_data, 32'h3000_0000);
    check("single_inflight_t5", in_flight, 0);

    // Signed product from requester 3 (pointer now 3): -0.5 * 0.5 = -0.25
    next_cycle();
    set_op(3, 32'hF800_0000, 32'h0800_0000);
    req_valid = 4'b1000; settle();
    check("signed_ready", req_ready, 4'b1000);
    next_cycle(); req_valid = '0;
    next_cycle(); next_cycle(); next_cycle(); settle();
    check("signed_rsp_valid", rsp_valid, 4'b1000);
    check("signed_rsp_data", rsp_data, 32'hFC00_0000);

    // All four valid from reset: requester i computes (i+1).0 * 1.0
    for (int unsigned i = 0; i < N; i++) set_op(i, (i + 1) << 28, Q_ONE);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; req_valid = '1; settle();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin
        next_cycle();
        if (c == 8) req_valid = '0;
        settle();
      end
      exp_ready = (c < 8) ? N'(1 << (c % 4)) : '0;
      exp_rsp   = (c >= 4 && c < 12) ? N'(1 << ((c - 4) % 4)) : '0;
      done_cnt  = (c > 4) ? ((c - 4 > 8) ? 8 : c - 4) : 0;
      exp_inf   = ((c > 8) ? 8 : c) - done_cnt;
      check($sformatf("rr_ready_c%0d", c), req_ready, exp_ready);
      check($sformatf("rr_rsp_valid_c%0d", c), rsp_valid, exp_rsp);
      check($sformatf("rr_in_flight_c%0d", c), in_flight, exp_inf);
      if (c >= 4 && c < 12)
        check($sformatf("rr_rsp_data_c%0d", c), rsp_data, ((c - 4) % 4 + 1) << 28);
    end

    // Fairness: one grant to requester 0 moves the pointer to 1, then 0 and 3 compete
    next_cycle();
    set_op(0, Q_ONE, Q_ONE); set_op(3, Q_ONE, Q_ONE);
    req_valid = 4'b0001; settle();
    check("fair_setup_ready", req_ready, 4'b0001);
    for (int c = 0; c < 6; c++) begin
      next_cycle(); req_valid = 4'b1001; settle();
      check($sformatf("fair_ready_c%0d", c), req_ready, (c % 2 == 0) ? 4'b1000 : 4'b0001);
    end
    next_cycle(); req_valid = '0;
    for (int c = 0; c < 6; c++) next_cycle();
    settle();
    check("fair_drained", in_flight, 0);

    // Grant enable low with two operations in flight (pointer is 1)
    set_op(1, 32'h3000_0000, 32'h0400_0000);
    set_op(2, 32'hE000_0000, 32'h2000_0000);
    req_valid = 4'b0110; settle();
    check("en_grant1", req_ready, 4'b0010);
    next_cycle(); settle();
    check("en_grant2", req_ready, 4'b0100);
    next_cycle(); en = 1'b0; settle();
    check("en_blocked_c2", req_ready, 0);
    check("en_inflight_c2", in_flight, 2);
    next_cycle(); settle();
    check("en_blocked_c3", req_ready, 0);
    next_cycle(); settle();
    check("en_rsp1_valid", rsp_valid, 4'b0010);
    check("en_rsp1_data", rsp_data, 32'h0C00_0000);
    next_cycle(); settle();
    check("en_rsp2_valid", rsp_valid, 4'b0100);
    check("en_rsp2_data", rsp_data, 32'hC000_0000);
    check("en_inflight_c5", in_flight, 1);
    next_cycle(); settle();
    check("en_inflight_c6", in_flight, 0);
    check("en_blocked_c6", req_ready, 0);
    req_valid = '0; en = 1'b1;

    // Back-to-back from requester 0: overflow wrap and truncation
    next_cycle();
    set_op(0, 32'h4000_0000, 32'h2800_0000); req_valid = 4'b0001; settle();
    check("arith_ready0", req_ready, 4'b0001);
    next_cycle(); set_op(0, 32'h0000_0003, 32'h0800_0000); settle();
    check("arith_ready1", req_ready, 4'b0001);
    next_cycle(); set_op(0, 32'hFFFF_FFFF, 32'h0800_0000); settle();
    check("arith_ready2", req_ready, 4'b0001);
    next_cycle(); req_valid = '0; settle();
    check("arith_inflight", in_flight, 3);
    next_cycle(); settle();
    check("arith_wrap_valid", rsp_valid, 4'b0001);
    check("arith_wrap_data", rsp_data, 32'hA000_0000);
    next_cycle(); settle();
    check("arith_trunc_pos", rsp_data, 32'h0000_0001);
    next_cycle(); settle();
    check("arith_trunc_neg", rsp_data, 32'hFFFF_FFFF);

    // Reset one cycle after a grant (pointer is 1)
    next_cycle();
    set_op(1, Q_ONE, Q_ONE); req_valid = 4'b0010; settle();
    check("mid_rst_grant", req_ready, 4'b0010);
    next_cycle(); rst = 1'b1; req_valid = '1; settle();
    check("mid_rst_ready_zero", req_ready, 0);
    check("mid_rst_inflight_pre", in_flight, 1);
    next_cycle(); rst = 1'b0; set_op(0, Q_ONE, 32'h0800_0000); settle();
    check("post_rst_ptr_zero", req_ready, 4'b0001);
    check("post_rst_inflight", in_flight, 0);
    check("post_rst_rsp_data", rsp_data, 0);
    next_cycle(); req_valid = '0; settle();
    check("post_rst_no_rsp_t3", rsp_valid, 0);
    next_cycle(); settle();
    check("post_rst_no_rsp_t4", rsp_valid, 0);
    next_cycle(); settle();
    check("post_rst_no_rsp_t5", rsp_valid, 0);
    next_cycle(); settle();
    check("post_rst_rsp_valid", rsp_valid, 4'b0001);
    check("post_rst_rsp_data2", rsp_data, 32'h0800_0000);
    next_cycle(); settle();
    check("post_rst_drained", in_flight, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
